muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer beside the EX stage, owning the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU from EX, holds the pipeline via `stall_req` while it iterates, then commits HI/LO. Also services MTHI/MTLO writes and drives HI/LO for MFHI/MFLO. The single-cycle EX ALU is untouched; this block is the only producer of HI/LO.

---
 rtl/muldiv_ctrl.sv | 142 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with
//               MTHI/MTLO writes. Optional macro DIV_ZERO_SKIP_EN makes a zero
//               divisor complete immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        flush,
    input  logic        hi_write_en,
    input  logic        lo_write_en,
    input  logic [31:0] write_data,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int DATA_BUS = 32;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mul  = 2'd1;
    localparam logic [1:0] c_div  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    localparam logic [5:0] c_last_iter = 6'd31;

    logic [1:0]          r_state;
    logic [5:0]          r_count;
    logic [DATA_BUS-1:0] r_opa;     // multiplicand / dividend, becomes quotient
    logic [DATA_BUS-1:0] r_opb;     // multiplier / divisor magnitude
    logic [DATA_BUS-1:0] r_rem;
    logic                r_qsign;
    logic                r_rsign;

    logic                w_op1_neg;
    logic                w_op2_neg;
    logic [DATA_BUS-1:0] w_mag1;
    logic [DATA_BUS-1:0] w_mag2;
    logic [63:0]         w_product;
    logic [63:0]         w_product_fix;
    logic [DATA_BUS:0]   w_shift;
    logic                w_ge;
    logic [DATA_BUS-1:0] w_sub;
    logic [DATA_BUS-1:0] w_rem_next;
    logic [DATA_BUS-1:0] w_quot_next;
    logic [DATA_BUS-1:0] w_rem_fix;
    logic [DATA_BUS-1:0] w_quot_fix;
    logic                w_accept;

    // Signed ops run on magnitudes; signs are reapplied at commit.
    assign w_op1_neg = ~op[0] & operand_1[DATA_BUS-1];
    assign w_op2_neg = ~op[0] & operand_2[DATA_BUS-1];
    assign w_mag1    = w_op1_neg ? (~operand_1 + 32'd1) : operand_1;
    assign w_mag2    = w_op2_neg ? (~operand_2 + 32'd1) : operand_2;

    assign w_product     = {32'd0, r_opa} * {32'd0, r_opb};
    assign w_product_fix = r_qsign ? (~w_product + 64'd1) : w_product;

    // One restoring step; the subtract only matters when it fits in 32 bits.
    assign w_shift     = {r_rem, r_opa[DATA_BUS-1]};
    assign w_ge        = w_shift >= {1'b0, r_opb};
    assign w_sub       = w_shift[DATA_BUS-1:0] - r_opb;
    assign w_rem_next  = w_ge ? w_sub : w_shift[DATA_BUS-1:0];
    assign w_quot_next = {r_opa[DATA_BUS-2:0], w_ge};
    assign w_quot_fix  = r_qsign ? (~w_quot_next + 32'd1) : w_quot_next;
    assign w_rem_fix   = r_rsign ? (~w_rem_next + 32'd1) : w_rem_next;

    assign w_accept  = (r_state == c_idle) && start && !flush;
    assign stall_req = w_accept || (r_state == c_mul) || (r_state == c_div);
    assign done      = (r_state == c_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_count <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_rem   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (flush) begin
            r_state <= c_idle;
            r_count <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_opa   <= w_mag1;
                        r_opb   <= w_mag2;
                        r_rem   <= '0;
                        r_qsign <= w_op1_neg ^ w_op2_neg;
                        r_rsign <= w_op1_neg;
                        r_count <= '0;
`ifdef DIV_ZERO_SKIP_EN
                        if (op[1] && (operand_2 == '0)) begin
                            hi      <= operand_1;
                            lo      <= '1;
                            r_state <= c_done;
                        end else begin
                            r_state <= op[1] ? c_div : c_mul;
                        end
`else
                        r_state <= op[1] ? c_div : c_mul;
`endif
                    end else begin
                        if (hi_write_en) hi <= write_data;
                        if (lo_write_en) lo <= write_data;
                    end
                end
                c_mul: begin
                    {hi, lo} <= w_product_fix;
                    r_state  <= c_done;
                end
                c_div: begin
                    r_opa <= w_quot_next;
                    r_rem <= w_rem_next;
                    if (r_count == c_last_iter) begin
                        hi      <= w_rem_fix;
                        lo      <= w_quot_fix;
                        r_count <= '0;
                        r_state <= c_done;
                    end else begin
                        r_count <= r_count + 6'd1;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed self-checking bench for muldiv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        flush = 1'b0;
    logic        hi_write_en = 1'b0;
    logic        lo_write_en = 1'b0;
    logic [31:0] write_data = '0;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] c_mult  = 2'b00;
    localparam logic [1:0] c_multu = 2'b01;
    localparam logic [1:0] c_div   = 2'b10;
    localparam logic [1:0] c_divu  = 2'b11;

`ifdef DIV_ZERO_SKIP_EN
    localparam int c_zlat = 1;
`else
    localparam int c_zlat = 33;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[10];

    muldiv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .flush       (flush),
        .hi_write_en (hi_write_en),
        .lo_write_en (lo_write_en),
        .write_data  (write_data),
        .stall_req   (stall_req),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int stalls = 0;
        int dcyc   = -1;
        start     = 1'b1;
        op        = o;
        operand_1 = a;
        operand_2 = b;
        for (int c = 0; c <= 40; c++) begin
            #1;
            if (done) begin
                dcyc = c;
                if (stall_req) stalls++;
                break;
            end
            if (stall_req) stalls++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, " done_cycle"}, 64'(dcyc), 64'(lat));
        chk({nm, " stall_cycles"}, 64'(stalls), 64'(lat));
        chk({nm, " hi"}, {32'd0, hi}, {32'd0, ehi});
        chk({nm, " lo"}, {32'd0, lo}, {32'd0, elo});
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{c_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{c_mult,  32'hFFFFFFFE, 32'd3,        2,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[2] = '{c_mult,  32'h80000000, 32'h80000000, 2,  32'h40000000, 32'h00000000};
        vecs[3] = '{c_mult,  32'hFFFFFFFB, 32'd7,        2,  32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[4] = '{c_div,   32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{c_divu,  32'd100,      32'd7,        33, 32'd2,        32'd14};
        vecs[6] = '{c_div,   32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000};
        vecs[7] = '{c_div,   32'd7,        32'hFFFFFFFE, 33, 32'd1,        32'hFFFFFFFD};
        vecs[8] = '{c_divu,  32'hFFFFFFFF, 32'h10,       33, 32'hF,        32'h0FFFFFFF};
        vecs[9] = '{c_divu,  32'd5,        32'd0,        c_zlat, 32'd5,    32'hFFFFFFFF};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].lat, vecs[i].ehi, vecs[i].elo);
        end

        // MTLO in IDLE after a MULT
        do_op("mult_pre_mtlo", c_mult, 32'hFFFFFFFE, 32'd3, 2, 32'hFFFFFFFF, 32'hFFFFFFFA);
        lo_write_en = 1'b1;
        write_data  = 32'h12345678;
        @(negedge clk);
        lo_write_en = 1'b0;
        #1;
        chk("mtlo lo", {32'd0, lo}, 64'h12345678);
        chk("mtlo hi", {32'd0, hi}, 64'hFFFFFFFF);
        @(negedge clk);

        // MTHI alongside start must be ignored
        hi_write_en = 1'b1;
        write_data  = 32'hDEADBEEF;
        start       = 1'b1;
        op          = c_multu;
        operand_1   = 32'd2;
        operand_2   = 32'd3;
        @(negedge clk);
        hi_write_en = 1'b0;
        #1;
        chk("mthi_with_start hi", {32'd0, hi}, 64'hFFFFFFFF);
        chk("mul cycle1 stall", {63'd0, stall_req}, 64'd1);
        @(negedge clk);
        #1;
        chk("mul cycle2 done", {63'd0, done}, 64'd1);
        chk("mul cycle2 lo", {32'd0, lo}, 64'd6);
        start = 1'b0;
        @(negedge clk);

        // Flush at division count 10
        do_op("divu_pre_flush", c_divu, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        start     = 1'b1;
        op        = c_divu;
        operand_1 = 32'd1000;
        operand_2 = 32'd3;
        repeat (11) @(negedge clk);
        start = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush cycle done", {63'd0, done}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("after flush stall", {63'd0, stall_req}, 64'd0);
        chk("after flush done", {63'd0, done}, 64'd0);
        chk("after flush hi", {32'd0, hi}, 64'd2);
        chk("after flush lo", {32'd0, lo}, 64'd14);
        #1;
        do_op("divu_post_flush", c_divu, 32'd1000, 32'd3, 33, 32'd1, 32'd333);

        // Asynchronous reset at division count 20
        start     = 1'b1;
        op        = c_divu;
        operand_1 = 32'd50;
        operand_2 = 32'd3;
        repeat (21) @(negedge clk);
        #1;
        chk("mid div stall", {63'd0, stall_req}, 64'd1);
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk("async rst hi", {32'd0, hi}, 64'd0);
        chk("async rst lo", {32'd0, lo}, 64'd0);
        chk("async rst stall", {63'd0, stall_req}, 64'd0);
        chk("async rst done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op("multu_post_rst", c_multu, 32'd3, 32'd4, 2, 32'd0, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
